seg_scan_ctrl: RTL and testbench

Time-multiplexing scheduler for the board's shared 4-digit, 7-segment display bus. Four digit sources (countdown, WALK symbol, HAND symbol, spare) share one active-low segment bus. The block rotates through the digits in fixed-length slots and inserts an anode-off blanking window at each slot start to suppress ghosting. It also applies per-digit enable and blink, and replaces the ad-hoc clock-divider-bit mux in the crosswalk top level.

---
 rtl/seg_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of four 7-segment digits over one
// shared active-low segment bus. Each digit owns a fixed-length slot that
// opens with an anode-off blanking window; per-digit enable and blink are
// applied on top, and all display outputs are registered.
module seg_scan_ctrl #(
  parameter int unsigned TICK_DIV     = 32768,
  parameter int unsigned BLANK_CYC    = 64,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [27:0] seg_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  dig_en,
  input  logic [3:0]  blink,
  output logic [6:0]  segs,
  output logic        dp,
  output logic [3:0]  an,
  output logic [1:0]  slot,
  output logic        frame_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYC);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  logic [6:0]    hold_seg_q, hold_seg_d;
  logic          hold_dp_q, hold_dp_d;
  logic          hold_en_q, hold_en_d;
  logic          hold_blink_q, hold_blink_d;

  logic [6:0]    segs_q, segs_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          ft_q, ft_d;

  logic          cnt_wrap;
  logic          frame_end;
  logic          in_window;
  logic          lit;
  logic [6:0]    sel_seg;
  logic          sel_dp, sel_en, sel_blink;

  // Lit window opens once the blanking prefix of the slot has elapsed.
  if (BLANK_CYC == 0) begin : g_noblank
    assign in_window = 1'b1;
  end else begin : g_blank
    assign in_window = (cnt_q >= BLANK_C);
  end

  // Select the inputs belonging to the digit that owns the current slot.
  always_comb begin
    sel_seg   = seg_in[6:0];
    sel_dp    = dp_in[0];
    sel_en    = dig_en[0];
    sel_blink = blink[0];
    case (slot_q)
      2'd1: begin
        sel_seg = seg_in[13:7];  sel_dp = dp_in[1];
        sel_en  = dig_en[1];     sel_blink = blink[1];
      end
      2'd2: begin
        sel_seg = seg_in[20:14]; sel_dp = dp_in[2];
        sel_en  = dig_en[2];     sel_blink = blink[2];
      end
      2'd3: begin
        sel_seg = seg_in[27:21]; sel_dp = dp_in[3];
        sel_en  = dig_en[3];     sel_blink = blink[3];
      end
      default: ;
    endcase
  end

  // Next-state for slot timing, blink phase, hold capture and display outputs.
  always_comb begin
    cnt_wrap  = (cnt_q == CNT_LAST);
    cnt_d     = cnt_wrap ? '0 : cnt_q + 1'b1;
    slot_d    = cnt_wrap ? slot_q + 2'd1 : slot_q;
    frame_end = cnt_wrap && (slot_q == 2'd3);

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // On cnt==0 the live inputs are used directly so that the digit is
    // already correct in that cycle (matters when BLANK_CYC==0); the same
    // values are what get held for the rest of the slot.
    if (cnt_q == '0) begin
      hold_seg_d   = sel_seg;
      hold_dp_d    = sel_dp;
      hold_en_d    = sel_en;
      hold_blink_d = sel_blink;
    end else begin
      hold_seg_d   = hold_seg_q;
      hold_dp_d    = hold_dp_q;
      hold_en_d    = hold_en_q;
      hold_blink_d = hold_blink_q;
    end

    lit    = in_window && en && hold_en_d && !(hold_blink_d && blink_phase_q);
    an_d   = lit ? ~(4'b0001 << slot_q) : 4'b1111;
    segs_d = lit ? hold_seg_d : 7'h7F;
    dp_d   = lit ? hold_dp_d : 1'b1;
    ft_d   = frame_end;
  end

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      slot_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      hold_seg_q    <= '1;
      hold_dp_q     <= 1'b1;
      hold_en_q     <= 1'b1;
      hold_blink_q  <= 1'b1;
      segs_q        <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= 4'b1111;
      ft_q          <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      hold_seg_q    <= hold_seg_d;
      hold_dp_q     <= hold_dp_d;
      hold_en_q     <= hold_en_d;
      hold_blink_q  <= hold_blink_d;
      segs_q        <= segs_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      ft_q          <= ft_d;
    end
  end

  assign segs       = segs_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign slot       = slot_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: stimulus pushes one expected output sample per
// clock cycle into a queue; a monitor pops and compares on the falling edge.
module tb_seg_scan_ctrl;

  localparam int TD = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b1;
  logic [27:0] seg_in;
  logic [3:0]  dp_in, dig_en, blink;
  logic [6:0]  segs;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  slot;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] segs;
    logic       dp;
    logic [1:0] slot;
    logic       ft;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  logic [6:0] h_seg[4];
  logic       h_dp[4];
  logic       h_en[4];
  logic       h_bl[4];
  logic       en_prev;
  int         k;

  seg_scan_ctrl #(
    .TICK_DIV(TD),
    .BLANK_CYC(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .seg_in(seg_in),
    .dp_in(dp_in),
    .dig_en(dig_en),
    .blink(blink),
    .segs(segs),
    .dp(dp),
    .an(an),
    .slot(slot),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic cmp(string nm, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s t=%0t: got=%0h want=%0h", nm, $time, act, want);
    end
  endtask

  // Monitor: one expected sample per cycle, compared away from the rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      cmp("an", int'(an), int'(mon_e.an));
      cmp("segs", int'(segs), int'(mon_e.segs));
      cmp("dp", int'(dp), int'(mon_e.dp));
      cmp("slot", int'(slot), int'(mon_e.slot));
      cmp("frame_tick", int'(frame_tick), int'(mon_e.ft));
    end
  end

  task automatic push_blank();
    exp_t e;
    e.an = 4'b1111; e.segs = 7'h7F; e.dp = 1'b1; e.slot = 2'd0; e.ft = 1'b0;
    q.push_back(e);
  endtask

  // Expected sample for cycle k (k counted from reset release, cnt==k%TD).
  task automatic cycle_scan();
    exp_t       e;
    int         p, ps, pc, f, s;
    logic       lit;
    logic [3:0] one = 4'b0001;
    if (k % TD == 0) begin
      s = (k / TD) % 4;
      h_seg[s] = seg_in[7*s +: 7];
      h_dp[s]  = dp_in[s];
      h_en[s]  = dig_en[s];
      h_bl[s]  = blink[s];
    end
    e.slot = 2'((k / TD) % 4);
    e.ft   = (k > 0) && (k % (4 * TD) == 0);
    lit = 1'b0;
    ps  = 0;
    if (k > 0) begin
      p   = k - 1;
      ps  = (p / TD) % 4;
      pc  = p % TD;
      f   = p / (4 * TD);
      lit = en_prev && h_en[ps] && (pc >= BC) && !(h_bl[ps] && ((f / BF) % 2 == 1));
    end
    e.an   = lit ? ~(one << ps) : 4'b1111;
    e.segs = lit ? h_seg[ps] : 7'h7F;
    e.dp   = lit ? h_dp[ps] : 1'b1;
    q.push_back(e);
    en_prev = en;
    k++;
  endtask

  initial begin
    seg_in = {7'h30, 7'h24, 7'h79, 7'h40};
    dp_in  = 4'b1010;
    dig_en = 4'b1111;
    blink  = 4'b0001;
    en     = 1'b1;
    k      = 0;

    // Held in reset: everything blank.
    repeat (3) begin
      @(posedge clk); #1;
      push_blank();
    end

    // Release; cycle 0 is the one in which reset goes high.
    @(posedge clk); #1;
    reset = 1'b1;
    k = 0;
    cycle_scan();

    while (k < 245) begin
      @(posedge clk); #1;
      case (k)
        4:   seg_in[6:0] = 7'h12;                  // mid-slot change in slot 0
        128: dig_en = 4'b0101;                     // frames 4-5: digits 0 and 2
        192: begin dig_en = 4'b1111; blink = 4'b0000; end
        196: en = 1'b0;                            // drop en inside lit window
        205: en = 1'b1;                            // raise en mid-slot
        default: ;
      endcase
      cycle_scan();
    end

    // Cycle 245 is slot 2, cnt 5: assert reset between edges.
    @(posedge clk); #1;
    push_blank();
    #2 reset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      push_blank();
    end

    // Restart: must repeat the basic scan from slot 0.
    @(posedge clk); #1;
    blink  = 4'b0000;
    seg_in = {7'h30, 7'h24, 7'h79, 7'h40};
    reset  = 1'b1;
    k = 0;
    cycle_scan();
    while (k < 40) begin
      @(posedge clk); #1;
      cycle_scan();
    end

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
